// File: rtl/sprite_collision_detector.sv
// Pixel-accurate player/enemy sprite collision detector.
// Counts overlapping opaque pixels per frame and raises a sticky hit at frame end.
module sprite_collision_detector #(
    parameter int         H_ACTIVE        = 640,
    parameter int         V_ACTIVE        = 480,
    parameter int         P_W             = 80,
    parameter int         P_H             = 121,
    parameter int         E_W             = 80,
    parameter int         E_H             = 121,
    parameter logic [2:0] TRANSPARENT     = 3'b000,
    parameter int         THRESHOLD       = 16,
    parameter int         COOLDOWN_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic [9:0]  player_x,
    input  logic [9:0]  player_y,
    input  logic [2:0]  player_data,
    input  logic [9:0]  enemy_x,
    input  logic [9:0]  enemy_y,
    input  logic [2:0]  enemy_data,
    input  logic        ack,
    output logic        collision,
    output logic        collision_pulse,
    output logic [15:0] overlap_count,
    output logic [9:0]  hit_x,
    output logic [9:0]  hit_y
);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        HIT      = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [10:0] H_ACT11  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT11  = 11'(V_ACTIVE);
    localparam logic [9:0]  V_ACT10  = 10'(V_ACTIVE);
    localparam logic [10:0] P_W11    = 11'(P_W);
    localparam logic [10:0] P_H11    = 11'(P_H);
    localparam logic [10:0] E_W11    = 11'(E_W);
    localparam logic [10:0] E_H11    = 11'(E_H);
    localparam logic [15:0] THRESH16 = 16'(THRESHOLD);
    localparam logic [3:0]  CD_INIT  = 4'(COOLDOWN_FRAMES);

    // Half-open interval test, widened to 11 bits so origin+size never wraps.
    function automatic logic in_span(input logic [9:0] pos, input logic [9:0] origin,
                                     input logic [10:0] size);
        logic [10:0] pos11;
        logic [10:0] org11;
        pos11 = {1'b0, pos};
        org11 = {1'b0, origin};
        return (pos11 >= org11) && (pos11 < (org11 + size));
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // Stage p0: register video position, sprite positions and pixel colours
    logic [9:0] hcount_p0;
    logic [9:0] vcount_p0;
    logic [9:0] player_x_p0;
    logic [9:0] player_y_p0;
    logic [9:0] enemy_x_p0;
    logic [9:0] enemy_y_p0;
    logic [2:0] player_data_p0;
    logic [2:0] enemy_data_p0;
    logic       vld_p0;

    always_ff @(posedge clk) begin
        hcount_p0      <= hcount;
        vcount_p0      <= vcount;
        player_x_p0    <= player_x;
        player_y_p0    <= player_y;
        enemy_x_p0     <= enemy_x;
        enemy_y_p0     <= enemy_y;
        player_data_p0 <= player_data;
        enemy_data_p0  <= enemy_data;
        vld_p0         <= ({1'b0, hcount} < H_ACT11) && ({1'b0, vcount} < V_ACT11);
    end

    // Stage p1: overlap qualification, frame-end detection and hit state
    logic in_player_p0;
    logic in_enemy_p0;
    logic overlap_p0;
    logic frame_end_cond;
    logic frame_end_q;
    logic frame_end;

    assign in_player_p0   = in_span(hcount_p0, player_x_p0, P_W11) &&
                            in_span(vcount_p0, player_y_p0, P_H11);
    assign in_enemy_p0    = in_span(hcount_p0, enemy_x_p0, E_W11) &&
                            in_span(vcount_p0, enemy_y_p0, E_H11);
    assign overlap_p0     = vld_p0 && in_player_p0 && in_enemy_p0 &&
                            (player_data_p0 != TRANSPARENT) &&
                            (enemy_data_p0 != TRANSPARENT);
    assign frame_end_cond = (vcount_p0 == V_ACT10) && (hcount_p0 == 10'd0);
    assign frame_end      = frame_end_cond && !frame_end_q;

    state_t      state;
    logic [15:0] acc;
    logic        first_hit;
    logic [3:0]  cooldown;
    logic [9:0]  shadow_x;
    logic [9:0]  shadow_y;
    logic        shadow_load;

    assign shadow_load = reset && !frame_end && overlap_p0 && !first_hit;

    always_ff @(posedge clk) begin
        if (shadow_load) begin
            shadow_x <= hcount_p0;
            shadow_y <= vcount_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= ARMED;
            collision       <= 1'b0;
            collision_pulse <= 1'b0;
            overlap_count   <= 16'd0;
            hit_x           <= 10'd0;
            hit_y           <= 10'd0;
            acc             <= 16'd0;
            first_hit       <= 1'b0;
            cooldown        <= 4'd0;
            frame_end_q     <= 1'b0;
        end else begin
            collision_pulse <= 1'b0;
            frame_end_q     <= frame_end_cond;

            if (frame_end) begin
                overlap_count <= acc;
                acc           <= 16'd0;
                first_hit     <= 1'b0;
            end else if (overlap_p0) begin
                acc <= sat_inc(acc);
                if (!first_hit) begin
                    first_hit <= 1'b1;
                end
            end

            case (state)
                ARMED: begin
                    if (frame_end && (acc >= THRESH16)) begin
                        state           <= HIT;
                        collision       <= 1'b1;
                        collision_pulse <= 1'b1;
                        hit_x           <= shadow_x;
                        hit_y           <= shadow_y;
                    end
                end
                HIT: begin
                    // ack takes priority over a coincident frame end: no re-hit this frame.
                    if (ack) begin
                        collision <= 1'b0;
                        if (COOLDOWN_FRAMES > 0) begin
                            cooldown <= CD_INIT;
                            state    <= COOLDOWN;
                        end else begin
                            state <= ARMED;
                        end
                    end
                end
                COOLDOWN: begin
                    if (frame_end) begin
                        if (cooldown <= 4'd1) begin
                            cooldown <= 4'd0;
                            state    <= ARMED;
                        end else begin
                            cooldown <= cooldown - 4'd1;
                        end
                    end
                end
                default: begin
                    state <= ARMED;
                end
            endcase
        end
    end

endmodule

// File: doc/sprite_collision_detector.md
Name: sprite_collision_detector

Overview:
- Pixel-accurate collision detector between the player car sprite and one enemy car sprite.
- Samples both sprites' pixel streams during active video, counts overlapping opaque pixels per frame, and raises a sticky `collision` level at end of frame.
- `collision` feeds the enemy's `collision` input, which freezes its descent, and is also read by the game control FSM.
- Sits beside the sprite generators on the pixel clock and consumes the same `hcount`/`vcount` the sprites use.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- P_W, 80, player sprite width in pixels.
- P_H, 121, player sprite height in lines.
- E_W, 80, enemy sprite width in pixels.
- E_H, 121, enemy sprite height in lines.
- TRANSPARENT, 3'b000, sprite pixel colour treated as empty.
- THRESHOLD, 16, minimum overlapping pixels in one frame to declare a hit (1..65535).
- COOLDOWN_FRAMES, 2, frames ignored after `ack` before re-arming (0..15).

Ports:
- clk  in  1  pixel clock, same clock as the sprite pixel logic.
- reset  in  1  synchronous, active-low reset.
- hcount  in  10  current pixel column.
- vcount  in  10  current line.
- player_x  in  10  player sprite left edge.
- player_y  in  10  player sprite top edge.
- player_data  in  3  player sprite pixel colour.
- enemy_x  in  10  enemy sprite left edge.
- enemy_y  in  10  enemy sprite top edge.
- enemy_data  in  3  enemy sprite pixel colour.
- ack  in  1  game FSM acknowledges the hit; clears `collision`.
- collision  out  1  sticky hit level.
- collision_pulse  out  1  one-cycle strobe in the cycle `collision` rises.
- overlap_count  out  16  overlap count of the last completed frame.
- hit_x  out  10  `hcount` of the first overlapping pixel in the hit frame.
- hit_y  out  10  `vcount` of the first overlapping pixel in the hit frame.

Behaviour:
- Reset (`reset`=0 at a `clk` edge):
  - Outputs: `collision`=0, `collision_pulse`=0, `overlap_count`=0, `hit_x`=0, `hit_y`=0.
  - Internals: accumulator=0, first-hit flag=0, cooldown=0, state=ARMED.
  - Reset overrides every other event, including mid-frame or in HIT.
- Sprite outputs hold their last value outside the sprite box, so a pixel is only valid inside the box:
  - player box: `hcount`∈[player_x, player_x+P_W) and `vcount`∈[player_y, player_y+P_H).
  - enemy box: the same test with the enemy position and E_W/E_H.
  - Box arithmetic is done at 11 bits so that x+W never wraps.
- overlap pixel = active (`hcount`<H_ACTIVE and `vcount`<V_ACTIVE) AND inside both boxes AND `player_data`≠TRANSPARENT AND `enemy_data`≠TRANSPARENT.
  - Inputs are registered one stage before evaluation, so latency is 1 clk from input to accumulator.
- Accumulator (16-bit) increments per overlap pixel and saturates at 16'hFFFF.
- First overlap pixel of a frame latches its registered `hcount`/`vcount` into shadow registers.
- Frame end = the first cycle where registered `vcount`==V_ACTIVE and `hcount`==0. At frame end:
  - `overlap_count` <= accumulator.
  - Accumulator clears; first-hit flag clears.
  - The state transition below is evaluated.
- States:
  - ARMED: at frame end, if accumulator>=THRESHOLD then go to HIT; `collision`<=1, `collision_pulse`<=1 for that one cycle, and `hit_x`/`hit_y` take the shadow values. Otherwise stay in ARMED.
  - HIT: `collision` held at 1. Accumulation continues and `overlap_count` keeps updating, but `hit_x`/`hit_y` are frozen. `ack`=1 gives `collision`<=0 next cycle and:
    - COOLDOWN_FRAMES>0: cooldown<=COOLDOWN_FRAMES, go to COOLDOWN.
    - COOLDOWN_FRAMES=0: go to ARMED.
  - COOLDOWN: cooldown decrements at each frame end, with no hit evaluation. When it reaches 0 the block goes to ARMED, and the next full frame is evaluated.
- Simultaneous events:
  - `ack` in the same cycle as frame end while in HIT: `ack` wins, so no re-hit that frame.
  - `ack` in ARMED or COOLDOWN is ignored.
- `collision_pulse` never asserts while `collision` is already 1.

Test Plan:
- Reset:
  - Hold `reset`=0 for 3 clks mid-frame while overlap is active → all outputs 0.
  - Release → the next frame end reports the count of the partial frame after release only.
- No overlap:
  - player (100,300) and enemy (300,300), both opaque, full frame → `overlap_count`=0, `collision`=0.
- Full overlap:
  - Both sprites at (200,100), both opaque → at frame end `overlap_count`=9680, `collision`=1, 1-cycle `collision_pulse`, `hit_x`=200, `hit_y`=100.
- Threshold edge (THRESHOLD=16):
  - enemy at (275,100), player at (200,100): 5 columns × 121 lines = 605 → hit.
  - Then player height limited via transparency to 3 lines × 5 columns = 15 → no hit.
  - Exactly 16 → hit.
- Transparency:
  - Full box overlap but `enemy_data`=3'b000 everywhere → `overlap_count`=0, no hit.
  - A stale nonzero `enemy_data` outside the enemy box must not count.
- Ack and cooldown (COOLDOWN_FRAMES=2):
  - With persistent overlap, pulse `ack` 1 clk → `collision`=0 next clk and stays 0 through 2 frame ends.
  - At the 3rd full frame end → `collision`=1 again.
  - `ack` coincident with frame end → no re-hit in that frame.
